// File: rtl/tri_bbox_raster.sv
// Flat-depth triangle rasterizer: scans the screen-clipped bounding box in raster
// order and emits one framebuffer/depth write per covered pixel.
//
// state | meaning
// IDLE  | waiting for start; vertices and depth latched on start
// SETUP | signed area, winding fix-up, clamped bounding box, reject check
// INIT  | edge values and per-x/per-y increments at (xmin, ymin)
// SCAN  | one pixel per clock, incremental edge update
// DONE  | one-cycle completion pulse
module tri_bbox_raster #(
  parameter int VERTEX_WIDTH  = 16,
  parameter int DEPTH_WIDTH   = 12,
  parameter int FB_WIDTH      = 160,
  parameter int FB_HEIGHT     = 120,
  parameter int FB_ADDR_WIDTH = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic signed [VERTEX_WIDTH-1:0] x0,
  input  logic signed [VERTEX_WIDTH-1:0] y0,
  input  logic signed [VERTEX_WIDTH-1:0] x1,
  input  logic signed [VERTEX_WIDTH-1:0] y1,
  input  logic signed [VERTEX_WIDTH-1:0] x2,
  input  logic signed [VERTEX_WIDTH-1:0] y2,
  input  logic [DEPTH_WIDTH-1:0]         z,
  output logic                           busy,
  output logic                           fb_write_enable,
  output logic [FB_ADDR_WIDTH-1:0]       fb_addr,
  output logic [DEPTH_WIDTH-1:0]         depth_data,
  output logic                           done
);

  localparam int EW = 2*VERTEX_WIDTH + 2;

  typedef logic signed [VERTEX_WIDTH-1:0] coord_t;
  typedef logic signed [EW-1:0]           acc_t;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_INIT, ST_SCAN, ST_DONE} state_t;

  localparam coord_t X_LIM = coord_t'(FB_WIDTH - 1);
  localparam coord_t Y_LIM = coord_t'(FB_HEIGHT - 1);
  localparam logic [FB_ADDR_WIDTH-1:0] ROW_STEP = FB_ADDR_WIDTH'(FB_WIDTH);

  function automatic acc_t edge_fn(input coord_t xi, input coord_t yi,
                                   input coord_t xj, input coord_t yj,
                                   input coord_t px, input coord_t py);
    return (acc_t'(xj) - acc_t'(xi)) * (acc_t'(py) - acc_t'(yi))
         - (acc_t'(yj) - acc_t'(yi)) * (acc_t'(px) - acc_t'(xi));
  endfunction

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  state_t state, state_nxt;

  coord_t                   vx0, vy0, vx1, vy1, vx2, vy2;
  logic [DEPTH_WIDTH-1:0]   z_q;
  coord_t                   xmin_q, xmax_q, ymin_q, ymax_q;
  coord_t                   px_q, py_q;
  acc_t                     e12_q, e20_q, e01_q;
  acc_t                     e12_row, e20_row, e01_row;
  acc_t                     sx12, sx20, sx01, sy12, sy20, sy01;
  logic [FB_ADDR_WIDTH-1:0] row_base;

  acc_t   area;
  coord_t bb_xlo, bb_xhi, bb_ylo, bb_yhi;
  coord_t cl_xlo, cl_xhi, cl_ylo, cl_yhi;
  logic   degenerate, box_empty, last_col, last_row;

  logic                     covered;
  logic                     we_d, done_d, busy_d;
  logic [FB_ADDR_WIDTH-1:0] addr_d;
  logic [DEPTH_WIDTH-1:0]   depth_d;

  always_comb begin
    area       = edge_fn(vx0, vy0, vx1, vy1, vx2, vy2);
    degenerate = (area == '0);
    bb_xlo     = min3(vx0, vx1, vx2);
    bb_xhi     = max3(vx0, vx1, vx2);
    bb_ylo     = min3(vy0, vy1, vy2);
    bb_yhi     = max3(vy0, vy1, vy2);
    cl_xlo     = bb_xlo[VERTEX_WIDTH-1] ? '0 : bb_xlo;
    cl_ylo     = bb_ylo[VERTEX_WIDTH-1] ? '0 : bb_ylo;
    cl_xhi     = (bb_xhi > X_LIM) ? X_LIM : bb_xhi;
    cl_yhi     = (bb_yhi > Y_LIM) ? Y_LIM : bb_yhi;
    // A fully offscreen triangle clamps to an inverted box.
    box_empty  = (cl_xhi < cl_xlo) || (cl_yhi < cl_ylo);
    last_col   = (px_q == xmax_q);
    last_row   = (py_q == ymax_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SETUP;
      ST_SETUP: state_nxt = (degenerate || box_empty) ? ST_DONE : ST_INIT;
      ST_INIT:  state_nxt = ST_SCAN;
      ST_SCAN:  if (last_col && last_row) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    covered = (state == ST_SCAN) && !e12_q[EW-1] && !e20_q[EW-1] && !e01_q[EW-1];
    we_d    = covered;
    addr_d  = covered ? (row_base + FB_ADDR_WIDTH'(px_q)) : '0;
    depth_d = covered ? z_q : '0;
    done_d  = (state_nxt == ST_DONE);
    busy_d  = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_write_enable <= 1'b0;
      fb_addr         <= '0;
      depth_data      <= '0;
      done            <= 1'b0;
      busy            <= 1'b0;
    end else begin
      fb_write_enable <= we_d;
      fb_addr         <= addr_d;
      depth_data      <= depth_d;
      done            <= done_d;
      busy            <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (start) begin
          vx0 <= x0; vy0 <= y0;
          vx1 <= x1; vy1 <= y1;
          vx2 <= x2; vy2 <= y2;
          z_q <= z;
        end
      end
      ST_SETUP: begin
        // Negative area: swap v1/v2 so covered pixels see non-negative edges.
        if (area[EW-1]) begin
          vx1 <= vx2; vy1 <= vy2;
          vx2 <= vx1; vy2 <= vy1;
        end
        xmin_q <= cl_xlo;
        xmax_q <= cl_xhi;
        ymin_q <= cl_ylo;
        ymax_q <= cl_yhi;
      end
      ST_INIT: begin
        px_q     <= xmin_q;
        py_q     <= ymin_q;
        e12_q    <= edge_fn(vx1, vy1, vx2, vy2, xmin_q, ymin_q);
        e20_q    <= edge_fn(vx2, vy2, vx0, vy0, xmin_q, ymin_q);
        e01_q    <= edge_fn(vx0, vy0, vx1, vy1, xmin_q, ymin_q);
        e12_row  <= edge_fn(vx1, vy1, vx2, vy2, xmin_q, ymin_q);
        e20_row  <= edge_fn(vx2, vy2, vx0, vy0, xmin_q, ymin_q);
        e01_row  <= edge_fn(vx0, vy0, vx1, vy1, xmin_q, ymin_q);
        sx12     <= acc_t'(vy1) - acc_t'(vy2);
        sx20     <= acc_t'(vy2) - acc_t'(vy0);
        sx01     <= acc_t'(vy0) - acc_t'(vy1);
        sy12     <= acc_t'(vx2) - acc_t'(vx1);
        sy20     <= acc_t'(vx0) - acc_t'(vx2);
        sy01     <= acc_t'(vx1) - acc_t'(vx0);
        row_base <= FB_ADDR_WIDTH'(ymin_q) * ROW_STEP;
      end
      ST_SCAN: begin
        if (last_col) begin
          px_q     <= xmin_q;
          py_q     <= py_q + coord_t'(1);
          e12_row  <= e12_row + sy12;
          e20_row  <= e20_row + sy20;
          e01_row  <= e01_row + sy01;
          e12_q    <= e12_row + sy12;
          e20_q    <= e20_row + sy20;
          e01_q    <= e01_row + sy01;
          row_base <= row_base + ROW_STEP;
        end else begin
          px_q  <= px_q + coord_t'(1);
          e12_q <= e12_q + sx12;
          e20_q <= e20_q + sx20;
          e01_q <= e01_q + sx01;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/tri_bbox_raster.md
# tri_bbox_raster

Single-triangle rasterizer placed directly upstream of the framebuffer and depth-buffer memories. It accepts three screen-space vertices plus a flat depth value and scans the triangle's screen-clipped bounding box in raster order, one pixel per clock. For every covered pixel it emits a linear framebuffer write address and the depth value. Its outputs drive the write port of the framebuffer/depth buffer pair in the `clk_100m` domain.

## Interface
- `VERTEX_WIDTH`, 16, signed vertex coordinate width
- `DEPTH_WIDTH`, 12, depth value width
- `FB_WIDTH`, 160, framebuffer width in pixels
- `FB_HEIGHT`, 120, framebuffer height in pixels
- `FB_ADDR_WIDTH`, 15, framebuffer address width; must satisfy `$clog2(FB_WIDTH*FB_HEIGHT)`
- `clk` in 1: single clock for all logic (`clk_100m` domain).
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request to rasterize the triangle on the vertex inputs; sampled only in IDLE.
- `x0`,`y0`,`x1`,`y1`,`x2`,`y2` in VERTEX_WIDTH each, signed: vertex coordinates, sampled with `start`.
- `z` in DEPTH_WIDTH: flat triangle depth, sampled with `start`.
- `busy` out 1: high whenever state ≠ IDLE.
- `fb_write_enable` out 1: covered-pixel strobe.
- `fb_addr` out FB_ADDR_WIDTH: `py*FB_WIDTH + px` of the strobed pixel.
- `depth_data` out DEPTH_WIDTH: latched `z`, valid with the strobe.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE → SETUP → INIT → SCAN → DONE → IDLE.
  - IDLE → SETUP requires `start`.
  - SETUP → DONE directly if the triangle is degenerate or its bounding box is empty.
- **IDLE:** on `start`, latch vertices and `z`. `start` is ignored in every other state.
- **SETUP** (1 cycle):
  - Edge function: E_ij(p) = (xj−xi)(py−yi) − (yj−yi)(px−xi).
  - Signed area: A = E_01(v2).
  - A == 0: degenerate, no writes.
  - A < 0: swap v1 and v2 so that all interiors are positive.
  - Bounding box = min/max of the vertices, clamped to [0, FB_WIDTH−1] × [0, FB_HEIGHT−1].
  - Box empty if xmax < xmin or ymax < ymin after clamping (triangle fully offscreen).
- **INIT** (1 cycle):
  - Evaluate E_12, E_20 and E_01 at (xmin, ymin).
  - Store the per-x and per-y increments of each edge.
- **SCAN:**
  - Visit every pixel of the box in order: x ascending, then y ascending.
  - Edge values update incrementally: add the x-step per pixel; at row end, restore the row start and add the y-step.
  - No multiplies inside SCAN.
  - Pixel is covered iff all three edge values are ≥ 0 (inclusive edges; no top-left rule).
- **DONE:** assert `done` for 1 cycle, then return to IDLE.
- Arithmetic:
  - Edge accumulators are signed, 2·VERTEX_WIDTH+2 bits, with no overflow.
  - `fb_addr` is computed from the clamped px/py, so it always falls in [0, FB_WIDTH·FB_HEIGHT−1].

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset at any point (including mid-SCAN): IDLE from the next cycle; `fb_write_enable`, `done` and `busy` are 0 in that cycle; no further writes.
- `start` sampled at edge N:
  - SETUP occupies cycle N+1.
  - INIT occupies cycle N+2.
  - SCAN occupies cycles N+3 … N+2+W·H, where W = xmax−xmin+1 and H = ymax−ymin+1.
- Outputs are registered: the write for the pixel scanned in cycle k appears in cycle k+1.
- The first possible write is in cycle N+4.
- `done` appears in cycle N+3+W·H, coinciding with the last pixel's write; IDLE from N+4+W·H.
- Degenerate or empty triangle: `done` in cycle N+2; no writes.
- `busy` is high from N+1 through the `done` cycle inclusive.
- A new `start` is accepted in the first IDLE cycle after `done`.

## Test plan
- **Basic triangle:** (0,0),(3,0),(0,3), z=100.
  - Exactly 10 writes: addresses 0,1,2,3,160,161,162,320,321,480.
  - `depth_data`=100 on every write.
  - `done` at N+19 (4×4 box).
- **Winding:** same vertices as (0,0),(0,3),(3,0) → identical 10 writes, same cycles.
- **Degenerate:** collinear (0,0),(5,5),(10,10) → zero writes, `done` at N+2, `busy` high only N+1..N+2.
- **Clipping:** (−10,−10),(200,−10),(−10,200).
  - Every `fb_addr` < 19200.
  - Address 0 written; address 19199 (pixel 159,119) not written.
  - 160·120 SCAN cycles.
- **Offscreen:** all vertices with x ≥ 200 → zero writes, `done` at N+2.
- **Control:**
  - `start` pulsed during SCAN is ignored: the write count is unchanged.
  - `rst` asserted mid-SCAN of test 1: the next cycle shows `busy`=0, `fb_write_enable`=0 and no `done`.
  - A subsequent `start` reproduces the test 1 result exactly.
